// File: rtl/rx_frame_buffer.sv
// Store-and-forward Ethernet RX buffer: a frame is released downstream only after its TLAST
// passes the error, runt, overflow and destination-MAC checks. Optional stats: RX_FRAME_STATS_EN.
module rx_frame_buffer #(
    parameter int DEPTH_LOG2      = 11,
    parameter int MIN_FRAME_BYTES = 14
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]  S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TUSER,
    output logic        S_AXIS_TREADY,
    output logic [7:0]  M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic [15:0] FRAME_COUNT,
    output logic [15:0] DROP_COUNT
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    logic [8:0]    r_mem [DEPTH];
    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_commit_q, r_rd_ptr;
    logic [PW-1:0] w_wr_nxt, w_used, w_commit_eff;
    logic          r_commit_pend, r_s_ready;
    logic [15:0]   r_byte_cnt, w_idx, w_cnt_new;
    logic          r_da_uc, r_da_bc;
    logic          r_out_valid, r_out_last;
    logic [7:0]    r_out_data, w_mac_byte;
    logic          w_accept, w_full, w_in_da, w_uc_new, w_bc_new, w_da_ok, w_good, w_da_fail;
    logic          w_we, w_commit_set, w_drop, w_avail, w_fetch, w_in_frame;

    assign w_accept     = S_AXIS_TVALID & r_s_ready;
    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_used == PW'(DEPTH));
    // A commit issued last cycle has not landed in r_commit_ptr yet; rollbacks must see it.
    assign w_commit_eff = r_commit_pend ? r_wr_ptr : r_commit_ptr;
    assign w_in_frame   = (r_state == RECV);
    assign w_idx        = w_in_frame ? r_byte_cnt : 16'd0;
    assign w_cnt_new    = !w_in_frame ? 16'd1 :
                          (r_byte_cnt == 16'hFFFF) ? 16'hFFFF : r_byte_cnt + 16'd1;
    assign w_in_da      = (w_idx < 16'd6);

    always_comb begin
        w_mac_byte = 8'h00;
        case (w_idx[2:0])
            3'd0:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[47:40];
            3'd1:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[39:32];
            3'd2:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[31:24];
            3'd3:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[23:16];
            3'd4:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[15:8];
            3'd5:    w_mac_byte = ACCELERATOR_MAC_ADDRESS[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    // Unicast and broadcast matches are tracked independently; a mix of the two is a miss.
    assign w_uc_new  = (!w_in_frame | r_da_uc) & (!w_in_da | (S_AXIS_TDATA == w_mac_byte));
    assign w_bc_new  = (!w_in_frame | r_da_bc) & (!w_in_da | (S_AXIS_TDATA == 8'hFF));
    assign w_da_ok   = (w_cnt_new >= 16'd6) & (w_uc_new | w_bc_new);
    assign w_good    = !S_AXIS_TUSER & (w_cnt_new >= 16'(MIN_FRAME_BYTES)) & w_da_ok;
    assign w_da_fail = (w_idx == 16'd5) & !w_uc_new & !w_bc_new;

    always_comb begin
        w_state_nxt  = r_state;
        w_we         = 1'b0;
        w_wr_nxt     = r_wr_ptr;
        w_commit_set = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE, RECV: begin
                if (w_accept) begin
                    if (w_full) begin
                        if (S_AXIS_TLAST) begin
                            w_drop      = 1'b1;
                            w_wr_nxt    = w_commit_eff;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DISCARD;
                        end
                    end else if (S_AXIS_TLAST) begin
                        w_state_nxt = IDLE;
                        if (w_good) begin
                            w_we         = 1'b1;
                            w_wr_nxt     = r_wr_ptr + PW'(1);
                            w_commit_set = 1'b1;
                        end else begin
                            w_drop   = 1'b1;
                            w_wr_nxt = w_commit_eff;
                        end
                    end else begin
                        w_we        = 1'b1;
                        w_wr_nxt    = r_wr_ptr + PW'(1);
                        w_state_nxt = w_da_fail ? DISCARD : RECV;
                    end
                end
            end
            DISCARD: begin
                if (w_accept && S_AXIS_TLAST) begin
                    w_drop      = 1'b1;
                    w_wr_nxt    = w_commit_eff;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (w_we)
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_commit_q    <= '0;
            r_commit_pend <= 1'b0;
            r_byte_cnt    <= '0;
            r_da_uc       <= 1'b0;
            r_da_bc       <= 1'b0;
            r_s_ready     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_nxt;
            r_commit_pend <= w_commit_set;
            r_s_ready     <= 1'b1;
            if (r_commit_pend)
                r_commit_ptr <= r_wr_ptr;
            // Extra stage so the read side lags a commit by two cycles.
            r_commit_q    <= r_commit_ptr;
            if (w_accept && r_state != DISCARD) begin
                r_byte_cnt <= w_cnt_new;
                r_da_uc    <= w_uc_new;
                r_da_bc    <= w_bc_new;
            end
        end
    end

    // Read side: the RAM's synchronous read lands directly in the output register.
    assign w_avail = (r_rd_ptr != r_commit_q);
    assign w_fetch = w_avail & (!r_out_valid | M_AXIS_TREADY);

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_fetch) begin
            {r_out_last, r_out_data} <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
            r_out_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + PW'(1);
        end else if (M_AXIS_TREADY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign S_AXIS_TREADY = r_s_ready;
    assign M_AXIS_TDATA  = r_out_data;
    assign M_AXIS_TVALID = r_out_valid;
    assign M_AXIS_TLAST  = r_out_last;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] r_frame_cnt, r_drop_cnt;
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_commit_pend) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop)        r_drop_cnt  <= r_drop_cnt + 16'd1;
        end
    end
    assign FRAME_COUNT = r_frame_cnt;
    assign DROP_COUNT  = r_drop_cnt;
`else
    assign FRAME_COUNT = 16'd0;
    assign DROP_COUNT  = 16'd0;
`endif

endmodule
